// File: rtl/netwalk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : netwalk_pkg
//  Purpose  : Shared widths, sizes and saturating-increment helper for the
//             netwalk flow table, meter and policer stages.
//  Revision : 1.0 - initial release
// ============================================================================
package netwalk_pkg;

  localparam int NW_ADDR_W    = 6;
  localparam int NW_CNT_W     = 32;
  localparam int NW_N_ENTRIES = 64;

  localparam logic [NW_CNT_W-1:0] NW_CNT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping to zero
  function automatic logic [NW_CNT_W-1:0] nw_sat_inc(input logic [NW_CNT_W-1:0] v);
    return (v == NW_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/netwalk_window_timer.sv
`default_nettype none
// ============================================================================
//  Module   : netwalk_window_timer
//  Purpose  : Free-running 0..WINDOW_CYCLES-1 counter; tick is high during the
//             last cycle of each window (the cycle on which it wraps).
//  Revision : 1.0 - initial release
// ============================================================================
module netwalk_window_timer #(
  parameter int WINDOW_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              c_tw   = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [c_tw-1:0] c_last = c_tw'(WINDOW_CYCLES - 1);

  logic [c_tw-1:0] cnt_q;
  logic [c_tw-1:0] cnt_d;

  // Tick on the terminal count and wrap back to zero on the following edge
  always_comb begin
    tick  = (cnt_q == c_last);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Timer register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/netwalk_meter_policer.sv
`default_nettype none
// ============================================================================
//  Module   : netwalk_meter_policer
//  Purpose  : Per-entry band policer behind the flow meter. Counts events per
//             entry inside a fixed time window and issues a registered
//             drop/pass decision one cycle after each event.
//  Revision : 1.0 - initial release
// ============================================================================
module netwalk_meter_policer
  import netwalk_pkg::*;
#(
  parameter int N_ENTRIES     = NW_N_ENTRIES,
  parameter int CNT_W         = NW_CNT_W,
  parameter int WINDOW_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 glbl_program_en,
  input  logic                 band_program_en,
  input  logic                 band_delete_en,
  input  logic [NW_ADDR_W-1:0] band_program_addr,
  input  logic [CNT_W-1:0]     band_program_rate,
  input  logic                 meter_count_valid,
  input  logic [NW_ADDR_W-1:0] meter_event_addr,
  output logic                 policer_decision_valid,
  output logic                 policer_drop,
  output logic [CNT_W-1:0]     policer_drop_total
);

  logic tick;

  netwalk_window_timer #(
    .WINDOW_CYCLES (WINDOW_CYCLES)
  ) u_window_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Entry storage; a clear fresh bit makes win_cnt read as zero, which lets
  // the whole table be reset for a new window in a single cycle.
  logic [CNT_W-1:0]     band_rate_q [N_ENTRIES];
  logic [CNT_W-1:0]     band_rate_d [N_ENTRIES];
  logic [CNT_W-1:0]     win_cnt_q   [N_ENTRIES];
  logic [CNT_W-1:0]     win_cnt_d   [N_ENTRIES];
  logic [N_ENTRIES-1:0] band_valid_q, band_valid_d;
  logic [N_ENTRIES-1:0] fresh_q, fresh_d;

  logic                 decision_valid_q, decision_valid_d;
  logic                 drop_q, drop_d;
  logic [CNT_W-1:0]     drop_total_q, drop_total_d;

  logic [CNT_W-1:0]     evt_eff;
  logic [CNT_W-1:0]     evt_new;
  logic                 evt_over;

  // Event evaluation, table update and programming. Later assignments win:
  // window clear, then event update, then a program/delete fresh-clear.
  // Counts written at the edge are visible to the next cycle's read, so
  // back-to-back events to one entry always see the latest count.
  always_comb begin
    band_rate_d  = band_rate_q;
    win_cnt_d    = win_cnt_q;
    band_valid_d = band_valid_q;
    fresh_d      = fresh_q;

    evt_eff  = (fresh_q[meter_event_addr] && !tick) ? win_cnt_q[meter_event_addr] : '0;
    evt_new  = nw_sat_inc(evt_eff);
    evt_over = band_valid_q[meter_event_addr] && (evt_new > band_rate_q[meter_event_addr]);

    decision_valid_d = meter_count_valid;
    drop_d           = meter_count_valid && evt_over;
    drop_total_d     = drop_d ? nw_sat_inc(drop_total_q) : drop_total_q;

    if (tick) begin
      fresh_d = '0;
    end

    if (meter_count_valid) begin
      win_cnt_d[meter_event_addr] = evt_new;
      fresh_d[meter_event_addr]   = 1'b1;
    end

    if (glbl_program_en) begin
      if (band_delete_en) begin
        band_valid_d[band_program_addr] = 1'b0;
        fresh_d[band_program_addr]      = 1'b0;
      end else if (band_program_en) begin
        band_rate_d[band_program_addr]  = band_program_rate;
        band_valid_d[band_program_addr] = 1'b1;
        fresh_d[band_program_addr]      = 1'b0;
      end
    end
  end

  // State and decision registers; reset also squashes a pending decision
  always_ff @(posedge clk) begin
    if (reset) begin
      band_rate_q      <= '{default: '0};
      win_cnt_q        <= '{default: '0};
      band_valid_q     <= '0;
      fresh_q          <= '0;
      decision_valid_q <= 1'b0;
      drop_q           <= 1'b0;
      drop_total_q     <= '0;
    end else begin
      band_rate_q      <= band_rate_d;
      win_cnt_q        <= win_cnt_d;
      band_valid_q     <= band_valid_d;
      fresh_q          <= fresh_d;
      decision_valid_q <= decision_valid_d;
      drop_q           <= drop_d;
      drop_total_q     <= drop_total_d;
    end
  end

  assign policer_decision_valid = decision_valid_q;
  assign policer_drop           = drop_q;
  assign policer_drop_total     = drop_total_q;

endmodule
`default_nettype wire

// File: doc/netwalk_meter_policer.md
Name: netwalk_meter_policer

Overview:
- Stage directly downstream of netwalk_flow_meter. Consumes each per-flow meter event (meter_count_valid plus the flow's 6-bit table address) and applies a per-entry band limit over a fixed time window.
- Emits a one-cycle drop/pass decision per event to the output action stage, and keeps a global drop counter.
- Entries are programmed over the same control path as the flow table and meter.

Parameters:
- N_ENTRIES, 64, number of meter/band entries; address width is 6.
- CNT_W, 32, width of the window counters, band rates and drop total.
- WINDOW_CYCLES, 1000000, window length in clk cycles; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- glbl_program_en  in  1  global program window; band writes accepted only while high
- band_program_en  in  1  write band_program_rate to band_program_addr and set that entry valid
- band_delete_en  in  1  clear the valid bit of band_program_addr
- band_program_addr  in  6  entry being programmed
- band_program_rate  in  32  maximum packets per window for the entry
- meter_count_valid  in  1  meter event strobe from netwalk_flow_meter
- meter_event_addr  in  6  entry of the event, aligned with meter_count_valid
- policer_decision_valid  out  1  decision strobe, one cycle after the event
- policer_drop  out  1  1 = drop, 0 = pass; qualified by policer_decision_valid
- policer_drop_total  out  32  saturating count of drop decisions

Behaviour:
- Reset:
  - policer_decision_valid=0, policer_drop=0, policer_drop_total=0.
  - All band_valid bits, fresh bits and window counters cleared.
  - Window timer = 0.
- Storage:
  - Per entry: band_rate[32], band_valid, win_cnt[32], fresh.
  - fresh=0 means win_cnt reads as 0.
- Window timer:
  - Counts 0..WINDOW_CYCLES-1, then wraps.
  - On the wrap cycle (tick), all 64 fresh bits clear in that single cycle.
- Event at cycle t (meter_count_valid=1, address a):
  - eff = (fresh[a] && !tick) ? win_cnt[a] : 0.
  - new = eff+1, saturating at 2^32-1.
  - At cycle t+1: win_cnt[a]=new and fresh[a]=1.
- Decision:
  - policer_decision_valid=1 at t+1 only (single-cycle pulse). Latency is 1 and the stage takes back-to-back events every cycle.
  - policer_drop = band_valid[a] && (new > band_rate[a]), registered.
  - Invalid entries always pass. A valid entry with rate 0 drops every event.
  - Dropped events are still counted in win_cnt.
- Drop total: increments by 1 for each drop decision and saturates at 2^32-1; it does not wrap.
- Programming:
  - Accepted only when glbl_program_en=1.
  - band_program_en writes band_rate, sets band_valid and clears fresh for that entry.
  - band_delete_en clears band_valid and fresh.
  - If both are high, delete wins.
  - Writes with glbl_program_en=0 are ignored.
  - Events keep being policed during the program window.
- Simultaneous events:
  - Event and tick in the same cycle: the event is counted as the first packet of the new window (new=1).
  - Event and program write to the same address in the same cycle: the decision uses the old rate and old count. After the cycle, the write's fresh-clear takes priority over the event update, so the next event sees count 0.
  - Back-to-back events to the same address must see the forwarded count (bypass from the t+1 write), never a stale value.
- Reset asserted mid-operation: clears everything on the next edge, and any pending decision is squashed.

Decomposition:
- Shared package netwalk_pkg: NW_ADDR_W=6, NW_CNT_W=32, NW_N_ENTRIES=64, and a saturating-increment constant/function. The meter and flow table reuse these.
- One natural sub-module, netwalk_window_timer: parameter WINDOW_CYCLES, outputs a one-cycle tick pulse.
- The counter/band array stays in the top-level module.

Test Plan:
- WINDOW_CYCLES=16. Program entry 0 with rate=3 (glbl_program_en=1), then 5 consecutive events to addr 0 -> decisions pass, pass, pass, drop, drop; policer_drop_total=2.
- Entry 5 never programmed, 10 events -> all pass; drop_total unchanged.
- Rate=3 on entry 0: 4 events, then wait past a tick, then 2 events -> first window ends in a drop; after the tick both events pass (count restarts at 1).
- Event to addr 0 placed exactly on the tick cycle -> counted as new=1, pass. Write entry 1 rate=0 with glbl_program_en=0 -> ignored, events pass. Same write with glbl_program_en=1 -> every event drops.
- Event and band_delete_en to addr 0 in the same cycle -> that decision uses the old band; the next event passes. Assert reset mid-stream -> next cycle valid=0 and drop_total=0; all entries pass afterwards.
